// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - radix constant and depth helpers shared by the mux tree
package mux_pkg;

   localparam int RADIX = 4;

   function automatic int clog4(input int n);
      int     levels;
      longint span;
      levels = 0;
      span   = 1;
      while (span < longint'(n)) begin
         span   = span * RADIX;
         levels = levels + 1;
      end
      return levels;
   endfunction

   function automatic bit n_in_legal(input int n);
      return (n >= RADIX) && ((longint'(1) << (2 * clog4(n))) == longint'(n));
   endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - input/output handshake bundle of the mux tree
interface mux_tree_pipe_if
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_IN  = 16
);
   localparam int SEL_W = 2 * clog4(N_IN);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]      in_sel;
   logic                  mode;
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_ch;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_sel, mode, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  in_data, in_sel, mode, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

endinterface

// File: rtl/mux4_stage_reg.sv
// rtl/mux4_stage_reg.sv - one registered radix-4 reduction level of the tree
module mux4_stage_reg
   import mux_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int GROUPS = 4,
   parameter int SEL_W  = 4,
   parameter int LVL    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          adv,
   input  logic                          in_valid,
   input  logic [GROUPS*RADIX*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]              in_ch,
   output logic                          out_valid,
   output logic [GROUPS*WIDTH-1:0]       out_data,
   output logic [SEL_W-1:0]              out_ch
);

   // The channel id doubles as the select; this level consumes its own digit.
   logic [1:0] pick;
   assign pick = in_ch[2*LVL +: 2];

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (adv) begin
         out_valid <= in_valid;
         if (in_valid) begin
            for (int g = 0; g < GROUPS; g++) begin
               out_data[g*WIDTH +: WIDTH] <= in_data[(g*RADIX + int'(pick))*WIDTH +: WIDTH];
            end
            out_ch <= in_ch;
         end
      end
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 mux tree with handshake and auto-scan
module mux_tree_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_IN  = 16
) (
   input logic           clk,
   input logic           rst,
   mux_tree_pipe_if.slave bus
);

   localparam int LEVELS = clog4(N_IN);
   localparam int SEL_W  = 2 * LEVELS;

   if (!n_in_legal(N_IN)) begin : g_bad_n_in
      $error("mux_tree_pipe: N_IN must be a power of 4 and at least 4");
   end

   logic             adv;
   logic             accept;
   logic             last_valid;
   logic [SEL_W-1:0] scan_ch;
   logic [SEL_W-1:0] eff_sel;

   assign adv          = bus.out_ready || !last_valid;
   assign accept       = bus.in_valid && adv;
   assign eff_sel      = bus.mode ? scan_ch : bus.in_sel;
   assign bus.in_ready = adv;

   // Held at zero outside scan so every entry into scan starts at channel 0.
   always_ff @(posedge clk) begin
      if (rst || !bus.mode) begin
         scan_ch <= '0;
      end else if (accept) begin
         scan_ch <= scan_ch + 1'b1;
      end
   end

   for (genvar L = 0; L < LEVELS; L++) begin : lvl
      localparam int GROUPS = N_IN >> (2 * (L + 1));

      logic                    v;
      logic [GROUPS*WIDTH-1:0] d;
      logic [SEL_W-1:0]        c;

      if (L == 0) begin : g_src
         mux4_stage_reg #(
            .WIDTH (WIDTH),
            .GROUPS(GROUPS),
            .SEL_W (SEL_W),
            .LVL   (L)
         ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .in_valid (accept),
            .in_data  (bus.in_data),
            .in_ch    (eff_sel),
            .out_valid(v),
            .out_data (d),
            .out_ch   (c)
         );
      end else begin : g_src
         mux4_stage_reg #(
            .WIDTH (WIDTH),
            .GROUPS(GROUPS),
            .SEL_W (SEL_W),
            .LVL   (L)
         ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .in_valid (lvl[L-1].v),
            .in_data  (lvl[L-1].d),
            .in_ch    (lvl[L-1].c),
            .out_valid(v),
            .out_data (d),
            .out_ch   (c)
         );
      end
   end

   assign last_valid    = lvl[LEVELS-1].v;
   assign bus.out_valid = lvl[LEVELS-1].v;
   assign bus.out_data  = lvl[LEVELS-1].d;
   assign bus.out_ch    = lvl[LEVELS-1].c;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench for mux_tree_pipe
module tb_mux_tree_pipe;

   localparam int WIDTH  = 8;
   localparam int N_IN   = 16;
   localparam int LEVELS = 2;
   localparam int LAST   = LEVELS - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_tree_pipe_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus ();

   mux_tree_pipe #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [7:0] chan [N_IN];
   for (genvar k = 0; k < N_IN; k++) begin : g_ch
      assign bus.in_data[k*WIDTH +: WIDTH] = chan[k];
   end

   // Reference: a delay line of beats plus a scan index, advancing on a global stall rule.
   bit         mv [LEVELS];
   logic [3:0] mc [LEVELS];
   logic [7:0] md [LEVELS];
   int         m_scan;
   int         got_q[$];
   int         n_checks;
   int         n_fail;

   task automatic tick();
      bit         adv, acc, mode_s;
      logic [3:0] sel;
      logic [7:0] dv;
      adv    = bus.out_ready || !mv[LAST];
      acc    = bus.in_valid && adv;
      mode_s = bus.mode;
      sel    = mode_s ? 4'(m_scan) : bus.in_sel;
      dv     = chan[sel];
      if (bus.out_valid === 1'b1 && bus.out_ready) got_q.push_back(int'(bus.out_ch));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < LEVELS; i++) mv[i] = 1'b0;
         m_scan = 0;
      end else begin
         if (adv) begin
            for (int i = LAST; i > 0; i--) begin
               mv[i] = mv[i-1]; mc[i] = mc[i-1]; md[i] = md[i-1];
            end
            mv[0] = acc; mc[0] = sel; md[0] = dv;
         end
         if (!mode_s) m_scan = 0;
         else if (acc) m_scan = (m_scan + 1) % N_IN;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.in_valid = 1'b1; bus.mode = 1'b0; bus.in_sel = 4'd5; bus.out_ready = 1'b1;
      tick(); tick();
      n_checks += 3;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", bus.out_valid); end
      if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h expected 00", bus.out_data); end
      if (bus.out_ch !== 4'd0) begin n_fail++; $display("FAIL reset_ch got %0d expected 0", bus.out_ch); end
      rst = 1'b0; bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_direct();
      bus.mode = 1'b0; bus.out_ready = 1'b1; bus.in_sel = 4'd9; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int e = 2; e <= 5; e++) begin
         tick();
         n_checks++;
         if (bus.out_valid !== (e == 2)) begin n_fail++; $display("FAIL direct_valid edge %0d got %b expected %b", e, bus.out_valid, e == 2); end
         if (e == 2) begin
            n_checks++;
            if (bus.out_data !== 8'h99 || bus.out_ch !== 4'd9) begin
               n_fail++; $display("FAIL direct_beat got ch %0d data %h expected ch 9 data 99", bus.out_ch, bus.out_data);
            end
         end
         n_checks++;
         if (bus.out_valid !== mv[LAST] || (mv[LAST] && bus.out_data !== md[LAST])) begin
            n_fail++; $display("FAIL direct_model got v%b %h expected v%b %h", bus.out_valid, bus.out_data, mv[LAST], md[LAST]);
         end
      end
   endtask

   task automatic test_streaming();
      bit exp_v;
      for (int c = 0; c < 20; c++) begin
         bus.in_valid = (c < 16); bus.in_sel = 4'(c);
         tick();
         exp_v = (c >= 1 && c <= 16);
         n_checks++;
         if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid cycle %0d got %b expected %b", c, bus.out_valid, exp_v); end
         if (exp_v) begin
            n_checks++;
            if (bus.out_ch !== 4'(c - 1) || bus.out_data !== 8'((c - 1) * 8'h11)) begin
               n_fail++; $display("FAIL stream_beat cycle %0d got ch %0d data %h expected ch %0d", c, bus.out_ch, bus.out_data, c - 1);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int nxt = 0, stall = 0;
      bit stalled_once = 1'b0;
      got_q.delete();
      bus.mode = 1'b0;
      for (int c = 0; c < 40; c++) begin
         bus.in_valid = (nxt < 16); bus.in_sel = 4'(nxt);
         if (!stalled_once && bus.out_valid === 1'b1 && bus.out_ch === 4'd4) begin stall = 3; stalled_once = 1'b1; end
         bus.out_ready = (stall == 0);
         #1;
         n_checks += 2;
         if (bus.in_ready !== (bus.out_ready || !mv[LAST])) begin n_fail++; $display("FAIL bp_ready cycle %0d got %b", c, bus.in_ready); end
         if (bus.out_valid !== mv[LAST] || (mv[LAST] && (bus.out_ch !== mc[LAST] || bus.out_data !== md[LAST]))) begin
            n_fail++; $display("FAIL bp_model cycle %0d got v%b ch %0d expected v%b ch %0d", c, bus.out_valid, bus.out_ch, mv[LAST], mc[LAST]);
         end
         if (stall > 0) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h44 || bus.out_ch !== 4'd4) begin
               n_fail++; $display("FAIL bp_hold cycle %0d got ready %b data %h expected ready 0 data 44", c, bus.in_ready, bus.out_data);
            end
            stall--;
         end
         if (bus.in_valid && (bus.out_ready || !mv[LAST])) nxt++;
         tick();
      end
      bus.out_ready = 1'b1;
      n_checks++;
      if (!stalled_once || got_q.size() != 16) begin n_fail++; $display("FAIL bp_count got %0d beats expected 16", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 16; i++) begin
         n_checks++;
         if (got_q[i] != i) begin n_fail++; $display("FAIL bp_order index %0d got %0d expected %0d", i, got_q[i], i); end
      end
   endtask

   task automatic test_scan();
      int sent = 0;
      got_q.delete();
      bus.mode = 1'b1; bus.out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         bus.in_valid = (sent < 18) && !(c == 6 || c == 7);
         #1;
         n_checks++;
         if (bus.out_valid !== mv[LAST] || (mv[LAST] && bus.out_ch !== mc[LAST])) begin
            n_fail++; $display("FAIL scan_model cycle %0d got v%b ch %0d expected v%b ch %0d", c, bus.out_valid, bus.out_ch, mv[LAST], mc[LAST]);
         end
         if (bus.in_valid) sent++;
         tick();
      end
      bus.in_valid = 1'b0; bus.mode = 1'b0;
      tick();
      n_checks++;
      if (got_q.size() != 18) begin n_fail++; $display("FAIL scan_count got %0d expected 18", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 18; i++) begin
         n_checks++;
         if (got_q[i] != i % 16) begin n_fail++; $display("FAIL scan_order index %0d got %0d expected %0d", i, got_q[i], i % 16); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < N_IN; k++) chan[k] = 8'($urandom);
         bus.mode      = ($urandom_range(0, 9) < 3);
         bus.in_sel    = 4'($urandom);
         bus.in_valid  = $urandom_range(0, 1);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         #1;
         n_checks += 2;
         if (bus.in_ready !== (bus.out_ready || !mv[LAST])) begin n_fail++; $display("FAIL rand_ready cycle %0d got %b", c, bus.in_ready); end
         if (bus.out_valid !== mv[LAST] || (mv[LAST] && (bus.out_ch !== mc[LAST] || bus.out_data !== md[LAST]))) begin
            n_fail++; $display("FAIL rand_model cycle %0d got v%b ch %0d data %h expected v%b ch %0d data %h",
                               c, bus.out_valid, bus.out_ch, bus.out_data, mv[LAST], mc[LAST], md[LAST]);
         end
         tick();
      end
      for (int k = 0; k < N_IN; k++) chan[k] = 8'(k * 8'h11);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.mode = 1'b0;
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_reset_midstream();
      bit tab_mode  [10] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
      bit tab_valid [10] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
      int expect_q[$] = '{0, 1, 2, 0, 1};
      bus.mode = 1'b0; bus.out_ready = 1'b1;
      bus.in_sel = 4'd3; bus.in_valid = 1'b1;
      tick();
      bus.in_sel = 4'd7; rst = 1'b1;
      tick();
      rst = 1'b0; bus.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid cycle %0d got %b expected 0", c, bus.out_valid); end
      end
      got_q.delete();
      for (int c = 0; c < 10; c++) begin
         bus.mode = tab_mode[c]; bus.in_valid = tab_valid[c];
         #1;
         n_checks++;
         if (bus.out_valid !== mv[LAST] || (mv[LAST] && bus.out_ch !== mc[LAST])) begin
            n_fail++; $display("FAIL reentry_model cycle %0d got v%b ch %0d expected v%b ch %0d", c, bus.out_valid, bus.out_ch, mv[LAST], mc[LAST]);
         end
         tick();
      end
      n_checks++;
      if (got_q != expect_q) begin n_fail++; $display("FAIL reentry_seq got %p expected %p", got_q, expect_q); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_fail = 0; m_scan = 0;
      for (int i = 0; i < LEVELS; i++) begin mv[i] = 1'b0; mc[i] = '0; md[i] = '0; end
      for (int k = 0; k < N_IN; k++) chan[k] = 8'(k * 8'h11);
      rst = 1'b1; bus.mode = 1'b0; bus.in_sel = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      test_reset();
      test_direct();
      test_streaming();
      test_backpressure();
      test_scan();
      test_random();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree built from registered radix-4 levels, with a valid/ready handshake and an optional auto-scan mode. It replaces fixed combinational 16:1 selectors where the input count, data width or timing closure needs to scale. Typical use: channel selection and round-robin sampling of wide status or data buses ahead of a serial or register-read path.

## Interface
- `WIDTH`, 8: data bits per channel, 1 or more.
- `N_IN`, 16: number of input channels. Must be a power of 4 (4, 16, 64, 256).
- `LEVELS`, derived as log4(N_IN): tree depth, equal to pipeline latency. Not overridable.
- `SEL_W`, derived as 2*LEVELS: select and channel-id width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input N_IN*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_sel` input SEL_W: channel select. Used only when mode=0.
- `mode` input 1: 0 means direct select, 1 means auto-scan.
- `in_valid` input 1: the beat is offered.
- `in_ready` output 1: the beat is accepted when in_valid && in_ready.
- `out_data` output WIDTH: the selected channel's data.
- `out_ch` output SEL_W: the channel index that produced out_data.
- `out_valid` output 1: the output beat is present.
- `out_ready` input 1: downstream accepts the beat.

## Operation
- **Effective select.** The effective select is `in_sel` when mode=0, and the internal `scan_ch` counter when mode=1.
- **Level 0 capture.** On acceptance, level 0 captures N_IN/4 partial results, each a 4:1 choice using select bits [1:0]. It also captures the remaining select bits, the full channel id and valid=1.
- **Later levels.** Level L reduces by 4 using select bits [2L+1:2L]. The final level drives out_data, out_ch and out_valid.
- **Pipeline advance.** `adv = out_ready || !out_valid`.
  - The whole pipeline shifts only when adv=1; the stall is global.
  - `in_ready = adv`. This is combinational from out_ready and the out_valid register.
  - An empty stage shifts in valid=0 when in_valid=0 or in_ready=0.
- **Data sampling.** in_data and the select are sampled only on the acceptance edge. Changes while stalled are ignored.
- **Scan counter (`scan_ch`).**
  - Held at 0 whenever mode=0, so entry into scan always starts at channel 0.
  - In mode=1 it increments by 1 on each accepted beat and wraps from N_IN-1 to 0.
  - No increment without acceptance.
- **Mode switching.** Switching mode mid-stream does not disturb beats already in flight. Each beat carries its own channel id.
- **Reset values.**
  - out_valid=0, out_data=0, out_ch=0.
  - All stage valids, data and select registers cleared to 0.
  - scan_ch=0.
  - in_ready=1 in the first cycle after reset.
- **Reset mid-operation.** All in-flight beats are discarded, with no partial output. Rst has priority over acceptance in the same cycle.

## Timing
- **Latency.** A beat accepted at edge T appears with out_valid=1 after edge T+LEVELS-1, i.e. LEVELS edges inclusive. For N_IN=16 this is 2 edges.
- **Throughput.** 1 beat per cycle with out_ready held at 1; no bubbles.
- **Backpressure.** With out_ready=0 and out_valid=1, all outputs hold stable and in_ready=0. The beat completes on the first edge with out_ready=1.
- **Simultaneous events.** Output consumption and input acceptance in the same cycle are legal and lossless.
- **Pipeline depth.** Maximum beats in flight equals LEVELS. No internal FIFO.

## Structure
- **Shared package `mux_pkg`:**
  - `clog4` function used to derive LEVELS.
  - Localparam for the radix (4).
  - An N_IN legality check: elaboration error if not a power of 4 or if N_IN < 4.
- **Sub-module `mux4_stage_reg`** (params WIDTH, GROUPS):
  - GROUPS registered 4:1 selects.
  - Carries valid, remaining select bits and channel id.
  - Enabled by `adv`, with synchronous reset.
- **Top level:**
  - Generate loop instantiating LEVELS copies of `mux4_stage_reg` (N_IN/4, N_IN/16, …, 1 group).
  - The scan counter.
  - The handshake logic.

## Test plan
Tests use WIDTH=8, N_IN=16, with channel k driven to k*0x11.
- **Reset.** Assert rst 2 cycles with in_valid=1 → out_valid=0, out_data=0x00, out_ch=0. After release, in_ready=1.
- **Direct select.** mode=0, in_sel=9, in_valid for 1 cycle, out_ready=1 → out_valid=1 exactly 2 edges later for 1 cycle, out_data=0x99, out_ch=9.
- **Streaming.** in_sel sweeps 0..15 on back-to-back cycles → 16 consecutive outputs 0x00, 0x11, …, 0xFF with no gaps, first at edge 2.
- **Backpressure.** Streaming, with out_ready=0 for 3 cycles on output ch=4 → out_data=0x44 held, in_ready=0 for those 3 cycles. Output then resumes at ch=4 with no loss or duplicate.
- **Scan mode.** mode=1, in_valid=1 for 18 beats → out_ch sequence 0..15, 0, 1. An in_valid gap of 2 cycles leaves the sequence unchanged, only delayed.
- **Reset mid-stream and mode re-entry.** rst pulsed while 2 beats are in flight → no output for those beats. Then mode 1→0→1 restarts the scan at ch=0.
